axi_crossbar_chan_arbiter: RTL and testbench

- Round-robin arbiter and multiplexer for one AXI channel of a crossbar master port.
- Collects REQ_NB slave-side valid/data/last streams and selects one.
- Drives the winner onto a single valid/ready stream that feeds the channel's axi_crossbar_pipeline stage directly downstream.
- Holds each grant until the beat handshake completes, or until the last beat when burst locking is enabled (W channel).

---
 rtl/axi_crossbar_chan_arbiter.sv | 110 +++++++++++
 tb/tb_axi_crossbar_chan_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_crossbar_chan_arbiter.sv
// Round-robin arbiter and multiplexer for one AXI channel of a crossbar
// master port. A grant is taken in IDLE and then held in BUSY until the
// beat handshake (or, with LOCK_ON_LAST, the last-beat handshake) completes.
module axi_crossbar_chan_arbiter #(
  parameter int REQ_NB       = 4,
  parameter int DATA_BUS_W   = 16,
  parameter bit LOCK_ON_LAST = 1'b0,
  localparam int ID_W        = (REQ_NB > 1) ? $clog2(REQ_NB) : 1
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic                         srst,
  input  logic [REQ_NB-1:0]            i_valid,
  input  logic [REQ_NB*DATA_BUS_W-1:0] i_data,
  input  logic [REQ_NB-1:0]            i_last,
  output logic [REQ_NB-1:0]            i_ready,
  output logic                         o_valid,
  output logic [DATA_BUS_W-1:0]        o_data,
  output logic                         o_last,
  input  logic                         o_ready,
  output logic [ID_W-1:0]              o_grant_id,
  output logic                         o_busy
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                state;
  logic [ID_W-1:0]       rr_ptr;
  logic [ID_W-1:0]       grant_q;

  logic                  found;
  logic [ID_W-1:0]       winner;
  logic                  release_grant;
  logic [ID_W-1:0]       next_ptr;
  logic [DATA_BUS_W-1:0] data_arr [REQ_NB];

  // Split the packed payload bus into one word per requester for muxing.
  always_comb begin
    for (int k = 0; k < REQ_NB; k++) begin
      data_arr[k] = i_data[k*DATA_BUS_W +: DATA_BUS_W];
    end
  end

  // Scan requesters starting at rr_ptr and wrapping; the first valid one wins.
  always_comb begin
    logic [ID_W-1:0] idx;
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = 0; i < REQ_NB; i++) begin
      idx = ID_W'((int'(rr_ptr) + i) % REQ_NB);
      if (!found && i_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // Route the granted requester to the downstream stream; everything is idle otherwise.
  always_comb begin
    o_valid = 1'b0;
    o_data  = '0;
    o_last  = 1'b0;
    i_ready = '0;
    if (state == BUSY) begin
      o_valid          = i_valid[grant_q];
      o_data           = data_arr[grant_q];
      o_last           = i_last[grant_q];
      i_ready[grant_q] = o_ready;
    end
  end

  // A grant ends on a handshake, or only on the last beat when bursts are locked.
  always_comb begin
    release_grant = (state == BUSY) && o_valid && o_ready && (!LOCK_ON_LAST || o_last);
    next_ptr      = ID_W'((int'(grant_q) + 1) % REQ_NB);
  end

  // Two-state grant machine; either reset source abandons any burst in flight.
  always_ff @(posedge aclk) begin
    if (!aresetn || srst) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      grant_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant_q <= winner;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (release_grant) begin
            state  <= IDLE;
            rr_ptr <= next_ptr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_grant_id = grant_q;
  assign o_busy     = (state == BUSY);

endmodule

// File: tb/tb_axi_crossbar_chan_arbiter.sv
// Directed bench: u0 is an AW/AR-style arbiter, u1 a W-style arbiter with
// burst locking. Both share clock and reset.
module tb_axi_crossbar_chan_arbiter;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        srst;

  logic [3:0]  v0, last0, rdy_out0;
  logic [63:0] d0;
  logic        rdy0, ov0, ol0, busy0;
  logic [15:0] od0;
  logic [1:0]  gid0;

  logic [3:0]  v1, last1, rdy_out1;
  logic [63:0] d1;
  logic        rdy1, ov1, ol1, busy1;
  logic [15:0] od1;
  logic [1:0]  gid1;

  int checks = 0;
  int errors = 0;
  int hs0    = 0;
  int hs_base;

  always #5 aclk = ~aclk;

  axi_crossbar_chan_arbiter #(.REQ_NB(4), .DATA_BUS_W(16), .LOCK_ON_LAST(1'b0)) u0 (
    .aclk(aclk), .aresetn(aresetn), .srst(srst),
    .i_valid(v0), .i_data(d0), .i_last(last0), .i_ready(rdy_out0),
    .o_valid(ov0), .o_data(od0), .o_last(ol0), .o_ready(rdy0),
    .o_grant_id(gid0), .o_busy(busy0)
  );

  axi_crossbar_chan_arbiter #(.REQ_NB(4), .DATA_BUS_W(16), .LOCK_ON_LAST(1'b1)) u1 (
    .aclk(aclk), .aresetn(aresetn), .srst(srst),
    .i_valid(v1), .i_data(d1), .i_last(last1), .i_ready(rdy_out1),
    .o_valid(ov1), .o_data(od1), .o_last(ol1), .o_ready(rdy1),
    .o_grant_id(gid1), .o_busy(busy1)
  );

  // Count u0 beat handshakes as seen on the clock edge.
  always @(posedge aclk) begin
    if (ov0 && rdy0) hs0 <= hs0 + 1;
  end

  // Keep the run bounded even if the sequence below stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge aclk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic ready);
    v0   = valid;
    rdy0 = ready;
  endtask

  initial begin
    aresetn = 1'b0;
    srst    = 1'b0;
    v0 = '0; last0 = '0; rdy0 = 1'b0;
    d0 = {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0};
    v1 = '0; last1 = '0; rdy1 = 1'b0; d1 = '0;

    // Reset state
    nextCycle();
    nextCycle();
    @(negedge aclk);
    checkOutput("rst_valid0", 32'(ov0), 32'd0);
    checkOutput("rst_busy0", 32'(busy0), 32'd0);
    checkOutput("rst_ready0", 32'(rdy_out0), 32'd0);
    checkOutput("rst_gid0", 32'(gid0), 32'd0);
    checkOutput("rst_data0", 32'(od0), 32'd0);
    checkOutput("rst_last0", 32'(ol0), 32'd0);
    checkOutput("rst_valid1", 32'(ov1), 32'd0);
    checkOutput("rst_busy1", 32'(busy1), 32'd0);

    // No requests for 10 cycles
    aresetn = 1'b1;
    for (int c = 0; c < 10; c++) begin
      nextCycle();
      @(negedge aclk);
      checkOutput("quiet_valid", 32'(ov0), 32'd0);
      checkOutput("quiet_ready", 32'(rdy_out0), 32'd0);
      checkOutput("quiet_busy", 32'(busy0), 32'd0);
    end

    // All four requesting: grants rotate 0,1,2,3,0 with an IDLE bubble between
    applyStimulus(4'b1111, 1'b1);
    for (int g = 0; g < 5; g++) begin
      nextCycle();
      @(negedge aclk);
      checkOutput("rr_busy", 32'(busy0), 32'd1);
      checkOutput("rr_gid", 32'(gid0), 32'(g % 4));
      checkOutput("rr_data", 32'(od0), 32'h00A0 + 32'(g % 4));
      checkOutput("rr_ready", 32'(rdy_out0), 32'd1 << (g % 4));
      nextCycle();
      @(negedge aclk);
      checkOutput("rr_bubble_valid", 32'(ov0), 32'd0);
      checkOutput("rr_bubble_data", 32'(od0), 32'd0);
    end
    applyStimulus(4'b0000, 1'b1);

    // Backpressure on requester 2 for 5 cycles, then one handshake
    applyStimulus(4'b0100, 1'b0);
    hs_base = hs0;
    for (int c = 0; c < 5; c++) begin
      nextCycle();
      @(negedge aclk);
      checkOutput("stall_valid", 32'(ov0), 32'd1);
      checkOutput("stall_data", 32'(od0), 32'h00A2);
      checkOutput("stall_ready", 32'(rdy_out0), 32'd0);
      checkOutput("stall_gid", 32'(gid0), 32'd2);
    end
    rdy0 = 1'b1;
    #1;
    checkOutput("unstall_ready", 32'(rdy_out0), 32'b0100);
    nextCycle();
    applyStimulus(4'b0000, 1'b1);
    @(negedge aclk);
    checkOutput("unstall_idle", 32'(busy0), 32'd0);
    checkOutput("unstall_valid", 32'(ov0), 32'd0);
    checkOutput("unstall_hs", 32'(hs0 - hs_base), 32'd1);

    // Locked 4-beat burst from requester 2 while requester 0 waits
    rdy1 = 1'b1;
    v1 = 4'b0100;
    d1[32 +: 16] = 16'h00B1;
    nextCycle();
    v1 = 4'b0101;
    d1[0 +: 16] = 16'h00C0;
    last1[0] = 1'b1;
    @(negedge aclk);
    checkOutput("lock_gid_b1", 32'(gid1), 32'd2);
    checkOutput("lock_data_b1", 32'(od1), 32'h00B1);
    checkOutput("lock_ready_b1", 32'(rdy_out1), 32'b0100);
    checkOutput("lock_last_b1", 32'(ol1), 32'd0);
    for (int b = 2; b <= 4; b++) begin
      nextCycle();
      d1[32 +: 16] = 16'h00B0 + 16'(b);
      last1[2] = (b == 4);
      @(negedge aclk);
      checkOutput("lock_busy", 32'(busy1), 32'd1);
      checkOutput("lock_gid", 32'(gid1), 32'd2);
      checkOutput("lock_data", 32'(od1), 32'h00B0 + 32'(b));
      checkOutput("lock_last", 32'(ol1), (b == 4) ? 32'd1 : 32'd0);
    end
    nextCycle();
    v1 = 4'b0001;
    last1[2] = 1'b0;
    @(negedge aclk);
    checkOutput("lock_bubble_busy", 32'(busy1), 32'd0);
    checkOutput("lock_bubble_valid", 32'(ov1), 32'd0);
    nextCycle();
    @(negedge aclk);
    checkOutput("lock_next_gid", 32'(gid1), 32'd0);
    checkOutput("lock_next_data", 32'(od1), 32'h00C0);
    nextCycle();
    v1 = 4'b0000;
    last1 = 4'b0000;
    @(negedge aclk);
    checkOutput("lock_done_busy", 32'(busy1), 32'd0);

    // aresetn pulse during beat 2 of a locked burst from requester 1
    v1 = 4'b0010;
    d1[16 +: 16] = 16'h00D1;
    nextCycle();
    @(negedge aclk);
    checkOutput("abort_gid", 32'(gid1), 32'd1);
    nextCycle();
    d1[16 +: 16] = 16'h00D2;
    aresetn = 1'b0;
    @(negedge aclk);
    checkOutput("abort_b2_busy", 32'(busy1), 32'd1);
    checkOutput("abort_b2_data", 32'(od1), 32'h00D2);
    nextCycle();
    aresetn = 1'b1;
    v1 = 4'b1000;
    last1[3] = 1'b1;
    d1[48 +: 16] = 16'h00E3;
    @(negedge aclk);
    checkOutput("abort_busy", 32'(busy1), 32'd0);
    checkOutput("abort_valid", 32'(ov1), 32'd0);
    checkOutput("abort_gid_rst", 32'(gid1), 32'd0);
    checkOutput("abort_ready", 32'(rdy_out1), 32'd0);
    nextCycle();
    @(negedge aclk);
    checkOutput("after_abort_gid", 32'(gid1), 32'd3);
    checkOutput("after_abort_data", 32'(od1), 32'h00E3);
    nextCycle();
    v1 = 4'b0000;
    rdy1 = 1'b0;
    @(negedge aclk);
    checkOutput("after_abort_idle", 32'(busy1), 32'd0);

    // srst while BUSY and stalled; pointer must return to 0
    applyStimulus(4'b0010, 1'b0);
    nextCycle();
    @(negedge aclk);
    checkOutput("srst_pre_busy", 32'(busy0), 32'd1);
    checkOutput("srst_pre_gid", 32'(gid0), 32'd1);
    hs_base = hs0;
    srst = 1'b1;
    nextCycle();
    srst = 1'b0;
    applyStimulus(4'b1010, 1'b0);
    @(negedge aclk);
    checkOutput("srst_busy", 32'(busy0), 32'd0);
    checkOutput("srst_valid", 32'(ov0), 32'd0);
    checkOutput("srst_gid", 32'(gid0), 32'd0);
    checkOutput("srst_data", 32'(od0), 32'd0);
    checkOutput("srst_ready", 32'(rdy_out0), 32'd0);
    checkOutput("srst_no_hs", 32'(hs0 - hs_base), 32'd0);
    nextCycle();
    @(negedge aclk);
    checkOutput("srst_ptr_gid", 32'(gid0), 32'd1);
    rdy0 = 1'b1;
    nextCycle();
    applyStimulus(4'b0000, 1'b0);
    @(negedge aclk);
    checkOutput("srst_final_hs", 32'(hs0 - hs_base), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
